// File: rtl/conv_out_packer.sv
// Packs a stream of 8-bit convolved pixels into 32-bit little-endian words, one row never
// sharing a word with the next, and queues them in a first-word fall-through FIFO.
module conv_out_packer #(
    parameter int OUT_W      = 127,
    parameter int OUT_H      = 127,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        last_word,
    output logic        frame_done,
    output logic        overflow
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [11:0] COL_LAST = 12'(OUT_W - 1);
    localparam logic [11:0] ROW_LAST = 12'(OUT_H - 1);

    logic [1:0]  lane;
    logic [11:0] col;
    logic [11:0] row;
    logic [31:0] partial;
    logic [31:0] push_word;
    logic        row_end;
    logic        frame_end;
    logic        push;

    logic [32:0] mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [32:0] head;
    logic        empty;
    logic        full;
    logic        pop;
    logic        write_en;

    assign row_end   = (col == COL_LAST);
    assign frame_end = row_end && (row == ROW_LAST);
    assign push      = valid_in && ((lane == 2'd3) || row_end);

    // The partial word is cleared on every push, so lanes above the current byte are already 0.
    assign push_word = partial | ({24'd0, data_in} << {lane, 3'b000});

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop      = !empty && word_ready;
    assign write_en = push && (!full || pop);

    assign head       = mem[rd_ptr[PW-1:0]];
    assign word_valid = !empty;
    assign word_out   = word_valid ? head[31:0] : 32'd0;
    assign last_word  = word_valid && head[32];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            lane    <= 2'd0;
            col     <= 12'd0;
            row     <= 12'd0;
            partial <= 32'd0;
        end else if (valid_in) begin
            partial <= push ? 32'd0 : push_word;
            if (row_end) begin
                lane <= 2'd0;
                col  <= 12'd0;
                row  <= frame_end ? 12'd0 : row + 12'd1;
            end else begin
                lane <= lane + 2'd1;
                col  <= col + 12'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst && write_en) begin
            mem[wr_ptr[PW-1:0]] <= {frame_end, push_word};
        end
    end

    // Full with a same-edge pop still accepts the push; only a push with no room is dropped.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            frame_done <= pop && head[32];
        end
    end

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed self-checking bench for conv_out_packer using three instances with
// different frame geometries sharing one clock and reset.
module tb_conv_out_packer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  data_a, data_b, data_c;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;
    logic [31:0] word_a, word_b, word_c;
    logic        wv_a, wv_b, wv_c;
    logic        last_a, last_b, last_c;
    logic        fd_a, fd_b, fd_c;
    logic        ov_a, ov_b, ov_c;

    int checks = 0;
    int errors = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] q_c[$];
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;
    int fd_cnt_c = 0;

    conv_out_packer #(.OUT_W(8), .OUT_H(1), .FIFO_DEPTH(8)) dut_a (
        .Clk(clk), .Rst(rst_n), .data_in(data_a), .valid_in(valid_a),
        .word_out(word_a), .word_valid(wv_a), .word_ready(ready_a),
        .last_word(last_a), .frame_done(fd_a), .overflow(ov_a)
    );

    conv_out_packer dut_b (
        .Clk(clk), .Rst(rst_n), .data_in(data_b), .valid_in(valid_b),
        .word_out(word_b), .word_valid(wv_b), .word_ready(ready_b),
        .last_word(last_b), .frame_done(fd_b), .overflow(ov_b)
    );

    conv_out_packer #(.OUT_W(5), .OUT_H(2), .FIFO_DEPTH(8)) dut_c (
        .Clk(clk), .Rst(rst_n), .data_in(data_c), .valid_in(valid_c),
        .word_out(word_c), .word_valid(wv_c), .word_ready(ready_c),
        .last_word(last_c), .frame_done(fd_c), .overflow(ov_c)
    );

    // Inputs are stable from posedge+1, so the negedge view predicts the next edge's pops.
    always @(negedge clk) begin
        if (rst_n && wv_a && ready_a) q_a.push_back({last_a, word_a});
        if (rst_n && wv_b && ready_b) q_b.push_back({last_b, word_b});
        if (rst_n && wv_c && ready_c) q_c.push_back({last_c, word_c});
        if (fd_a) fd_cnt_a++;
        if (fd_b) fd_cnt_b++;
        if (fd_c) fd_cnt_c++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q_a.delete(); q_b.delete(); q_c.delete();
        fd_cnt_a = 0; fd_cnt_b = 0; fd_cnt_c = 0;
    endtask

    task automatic send_a(input logic [7:0] b);
        data_a = b; valid_a = 1'b1; tick(); valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        data_b = b; valid_b = 1'b1; tick(); valid_b = 1'b0;
    endtask

    task automatic test_reset();
        ready_a = 1'b0;
        data_a = 8'hFF; valid_a = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        valid_a = 1'b0;
        checks++; if (wv_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_word_valid: got %b expected 0", wv_a); end
        checks++; if (word_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_word_out: got %h expected 00000000", word_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_last_word: got %b expected 0", last_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", ov_a); end
        checks++; if (fd_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", fd_a); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_pack();
        do_reset();
        ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_a(8'(i));
            if (i == 4) begin
                checks++; if (wv_a !== 1'b1 || word_a !== 32'h04030201) begin errors++;
                    $display("[TB] FAIL fwft_latency: got valid=%b word=%h expected valid=1 word=04030201", wv_a, word_a); end
            end
        end
        repeat (4) tick();
        checks++; if (q_a.size() !== 2) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[0] !== {1'b0, 32'h04030201}) begin errors++; $display("[TB] FAIL basic_word0: got %h expected 004030201", q_a[0]); end
            checks++; if (q_a[1] !== {1'b1, 32'h08070605}) begin errors++; $display("[TB] FAIL basic_word1: got %h expected 108070605", q_a[1]); end
        end
        checks++; if (fd_cnt_a !== 1) begin errors++; $display("[TB] FAIL basic_frame_done: got %0d expected 1", fd_cnt_a); end
        checks++; if (wv_a !== 1'b0 || word_a !== 32'd0 || last_a !== 1'b0) begin errors++;
            $display("[TB] FAIL empty_outputs: got valid=%b word=%h last=%b expected all 0", wv_a, word_a, last_a); end
    endtask

    task automatic test_overflow();
        logic [32:0] exp;
        do_reset();
        ready_a = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            if (i == 36) begin
                checks++; if (ov_a !== 1'b0) begin errors++; $display("[TB] FAIL overflow_early: got %b expected 0", ov_a); end
            end
            send_a(8'(i));
        end
        tick();
        checks++; if (ov_a !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %b expected 1", ov_a); end
        checks++; if (wv_a !== 1'b1 || word_a !== 32'h04030201) begin errors++;
            $display("[TB] FAIL overflow_head_stable: got valid=%b word=%h expected valid=1 word=04030201", wv_a, word_a); end
        ready_a = 1'b1;
        repeat (12) tick();
        ready_a = 1'b0;
        tick();
        checks++; if (q_a.size() !== 8) begin errors++; $display("[TB] FAIL overflow_drain_count: got %0d expected 8", q_a.size()); end
        for (int k = 0; k < 8 && k < q_a.size(); k++) begin
            exp = {1'(k % 2), 8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            checks++; if (q_a[k] !== exp) begin errors++; $display("[TB] FAIL overflow_word%0d: got %h expected %h", k, q_a[k], exp); end
        end
        checks++; if (fd_cnt_a !== 4) begin errors++; $display("[TB] FAIL overflow_frame_done: got %0d expected 4", fd_cnt_a); end
        checks++; if (ov_a !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %b expected 1", ov_a); end
        checks++; if (wv_a !== 1'b0) begin errors++; $display("[TB] FAIL overflow_empty: got %b expected 0", wv_a); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        ready_a = 1'b0;
        for (int i = 1; i <= 35; i++) send_a(8'(i));
        checks++; if (ov_a !== 1'b0 || wv_a !== 1'b1) begin errors++;
            $display("[TB] FAIL full_state: got ov=%b valid=%b expected ov=0 valid=1", ov_a, wv_a); end
        ready_a = 1'b1;
        send_a(8'd36);
        ready_a = 1'b0;
        checks++; if (ov_a !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_overflow: got %b expected 0", ov_a); end
        checks++; if (word_a !== 32'h08070605) begin errors++; $display("[TB] FAIL full_pushpop_head: got %h expected 08070605", word_a); end
        ready_a = 1'b1;
        repeat (12) tick();
        ready_a = 1'b0;
        checks++; if (q_a.size() !== 9) begin errors++; $display("[TB] FAIL full_pushpop_count: got %0d expected 9", q_a.size()); end
        if (q_a.size() >= 9) begin
            checks++; if (q_a[7] !== {1'b1, 32'h201F1E1D}) begin errors++; $display("[TB] FAIL full_pushpop_word7: got %h expected 1201f1e1d", q_a[7]); end
            checks++; if (q_a[8] !== {1'b0, 32'h24232221}) begin errors++; $display("[TB] FAIL full_pushpop_word8: got %h expected 024232221", q_a[8]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ready_a = 1'b0;
        for (int i = 0; i < 6; i++) send_a(8'hC1 + 8'(i));
        rst_n = 1'b0;
        data_a = 8'hEE; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        rst_n = 1'b1;
        checks++; if (wv_a !== 1'b0 || word_a !== 32'd0) begin errors++;
            $display("[TB] FAIL midreset_flush: got valid=%b word=%h expected valid=0 word=00000000", wv_a, word_a); end
        q_a.delete(); fd_cnt_a = 0;
        ready_a = 1'b1;
        for (int i = 0; i < 8; i++) send_a(8'hA1 + 8'(i));
        repeat (4) tick();
        checks++; if (q_a.size() !== 2) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[0] !== {1'b0, 32'hA4A3A2A1}) begin errors++; $display("[TB] FAIL midreset_word0: got %h expected 0a4a3a2a1", q_a[0]); end
            checks++; if (q_a[1] !== {1'b1, 32'hA8A7A6A5}) begin errors++; $display("[TB] FAIL midreset_word1: got %h expected 1a8a7a6a5", q_a[1]); end
        end
        checks++; if (fd_cnt_a !== 1) begin errors++; $display("[TB] FAIL midreset_frame_done: got %0d expected 1", fd_cnt_a); end
    endtask

    task automatic test_row_padding();
        do_reset();
        ready_b = 1'b1;
        for (int i = 0; i < 127; i++) send_b(8'(i));
        repeat (4) tick();
        checks++; if (q_b.size() !== 32) begin errors++; $display("[TB] FAIL pad_count: got %0d expected 32", q_b.size()); end
        if (q_b.size() >= 32) begin
            checks++; if (q_b[0] !== {1'b0, 32'h03020100}) begin errors++; $display("[TB] FAIL pad_word0: got %h expected 003020100", q_b[0]); end
            checks++; if (q_b[30] !== {1'b0, 32'h7B7A7978}) begin errors++; $display("[TB] FAIL pad_word30: got %h expected 07b7a7978", q_b[30]); end
            checks++; if (q_b[31] !== {1'b0, 32'h007E7D7C}) begin errors++; $display("[TB] FAIL pad_word31: got %h expected 0007e7d7c", q_b[31]); end
        end
        q_b.delete();
        send_b(8'h55); send_b(8'h66); send_b(8'h77); send_b(8'h88);
        repeat (4) tick();
        checks++; if (q_b.size() !== 1) begin errors++; $display("[TB] FAIL pad_next_count: got %0d expected 1", q_b.size()); end
        if (q_b.size() >= 1) begin
            checks++; if (q_b[0] !== {1'b0, 32'h88776655}) begin errors++; $display("[TB] FAIL pad_next_word: got %h expected 088776655", q_b[0]); end
        end
        checks++; if (fd_cnt_b !== 0) begin errors++; $display("[TB] FAIL pad_frame_done: got %0d expected 0", fd_cnt_b); end
    endtask

    task automatic test_sparse();
        logic [32:0] exp [6];
        exp[0] = {1'b0, 32'h04030201};
        exp[1] = {1'b0, 32'h00000005};
        exp[2] = {1'b0, 32'h09080706};
        exp[3] = {1'b1, 32'h0000000A};
        exp[4] = {1'b0, 32'h0E0D0C0B};
        exp[5] = {1'b0, 32'h0000000F};
        do_reset();
        ready_c = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            data_c = 8'(i); valid_c = 1'b1;
            tick();
            valid_c = 1'b0;
            tick(); tick();
        end
        repeat (4) tick();
        checks++; if (q_c.size() !== 6) begin errors++; $display("[TB] FAIL sparse_count: got %0d expected 6", q_c.size()); end
        for (int k = 0; k < 6 && k < q_c.size(); k++) begin
            checks++; if (q_c[k] !== exp[k]) begin errors++; $display("[TB] FAIL sparse_word%0d: got %h expected %h", k, q_c[k], exp[k]); end
        end
        checks++; if (fd_cnt_c !== 1) begin errors++; $display("[TB] FAIL sparse_frame_done: got %0d expected 1", fd_cnt_c); end
    endtask

    initial begin
        rst_n = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        test_reset();
        test_basic_pack();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_row_padding();
        test_sparse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_packer.md
CONV_OUT_PACKER -- requirements
Module: conv_out_packer

Interface
REQ-001 Parameter OUT_W, default 127, means output pixels per row (legal range 1..4095).
REQ-002 Parameter OUT_H, default 127, means output rows per frame (legal range 1..4095).
REQ-003 Parameter FIFO_DEPTH, default 8, means word FIFO entries (power of 2, minimum 2).
REQ-004 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port data_in, input, 8 bits: convolved pixel from the upstream conv stage.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is accepted on any rising edge where valid_in=1.
REQ-008 The block SHALL have port word_out, output, 32 bits: packed word at the FIFO head.
REQ-009 The block SHALL have port word_valid, output, 1 bit: FIFO is non-empty.
REQ-010 The block SHALL have port word_ready, input, 1 bit: consumer accepts word_out.
REQ-011 The block SHALL have port last_word, output, 1 bit: the head word holds the final pixel of a frame.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky word-drop flag.

Function
REQ-014 Packing: bytes SHALL fill lanes in arrival order. Lane 0 is word bits [7:0] and lane 3 is bits [31:24].
REQ-015 A lane counter (0..3), column counter (0..OUT_W-1) and row counter (0..OUT_H-1) SHALL advance only on accepted bytes.
REQ-016 A word SHALL be pushed on the same edge that accepts a byte if that byte fills lane 3 or is the last column of a row.
REQ-017 On a row-end push, unfilled lanes SHALL be 0. The lane counter SHALL return to 0 and the column counter SHALL wrap to 0.
REQ-018 Each row SHALL therefore produce ceil(OUT_W/4) words, and a word SHALL never span two rows.
REQ-019 At the last column of the last row, the pushed word SHALL carry a last flag. The row counter SHALL wrap to 0 and the next byte SHALL start a new frame.
REQ-020 The FIFO SHALL be first-word fall-through. A word pushed on edge N SHALL give word_valid=1 and valid word_out/last_word from edge N+1 when the FIFO was empty.
REQ-021 A pop SHALL occur on an edge with word_valid=1 and word_ready=1. word_out SHALL be held stable while word_valid=1 and word_ready=0.
REQ-022 Simultaneous push and pop SHALL both take effect at any occupancy, including full, and occupancy SHALL be unchanged.
REQ-023 A push when the FIFO is full and there is no same-edge pop SHALL drop the word and set overflow=1 until reset. Packing and counters SHALL continue unaffected.
REQ-024 frame_done SHALL pulse for exactly one cycle, on the cycle after the edge that pops a word with last flag set.
REQ-025 Pop when empty SHALL have no effect, and word_valid SHALL remain 0.
REQ-026 word_out and last_word SHALL be 0 whenever word_valid=0.

Reset
REQ-027 On a rising edge with Rst=0, the block SHALL clear all counters, the partial word, the FIFO pointers, overflow and frame_done.
REQ-028 Under the same reset edge, word_valid SHALL be 0, word_out SHALL be 0 and last_word SHALL be 0.
REQ-029 Reset mid-row or mid-frame SHALL discard the partial word and all queued words. The first byte after reset release SHALL be column 0, row 0, lane 0.
REQ-030 valid_in SHALL be ignored on any edge where Rst=0.

Verification
REQ-031 Scenario, basic pack: OUT_W=8, OUT_H=1, word_ready=1, bytes 01..08 sent back-to-back. Required response: words 04030201 then 08070605; last_word=1 on the second word only; one frame_done pulse.
REQ-032 Scenario, row-end padding: OUT_W=127 (default), row of bytes 00..7E. Required response: 32 words; the final word is 007E7D7C; the next byte lands in lane 0 of a new word.
REQ-033 Scenario, backpressure and overflow: FIFO_DEPTH=8, word_ready=0, 36 bytes pushed. Required response: 8 words queued; the 9th word dropped and overflow=1. Then word_ready=1 drains exactly 8 words in order.
REQ-034 Scenario, full with simultaneous push/pop: FIFO full, word_ready=1 on the edge a word completes. Required response: no drop, overflow stays 0, occupancy stays 8.
REQ-035 Scenario, mid-frame reset: Rst=0 for 1 cycle after 6 bytes of an OUT_W=8 row. Required response: word_valid=0 next cycle; bytes A1..A8 afterwards yield A4A3A2A1 and A8A7A6A5.
REQ-036 Scenario, sparse strobes: valid_in asserted every 3rd cycle with OUT_W=5, OUT_H=2. Required response: words 04030201, 00000005, 09080706, 0000000A; last_word set on the 4th word; counters idle between strobes.
